sdram_init_refresh: RTL and testbench

// - Command sequencer between PLL-lock/CKE power-up logic and the SDRAM read/write arbiter.
// - Once the upstream stage has locked the clock and raised CKE, runs the JEDEC init:

---
 rtl/sdram_init_refresh.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sdram_init_refresh.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_refresh.sv
// sdram_init_refresh
// Command sequencer sitting between the PLL-lock/CKE power-up logic and the SDRAM
// read/write arbiter. While start is high it runs the JEDEC init sequence
// (power-up wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER) and then
// requests periodic AUTO REFRESH from the arbiter through refresh_req/refresh_grant.
// Build macro SDRAM_INIT_FAST_SIM_EN: power-up wait becomes 16 cycles and the
// refresh interval becomes 64 cycles (simulation only). Undefined by default.
module sdram_init_refresh #(
    parameter int unsigned CLK_MHZ          = 166,
    parameter int unsigned POWERUP_US       = 200,
    parameter int unsigned INIT_REFRESHES   = 8,
    parameter int unsigned T_RP             = 3,
    parameter int unsigned T_RFC            = 10,
    parameter int unsigned T_MRD            = 2,
    parameter int unsigned REFRESH_INTERVAL = 1296,
    parameter logic [12:0] MODE_REG         = 13'h030
) (
    input  logic        dram_clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        cmd_cs_n,
    output logic        cmd_ras_n,
    output logic        cmd_cas_n,
    output logic        cmd_we_n,
    output logic [12:0] cmd_addr,
    output logic [1:0]  cmd_ba,
    output logic        init_done,
    output logic        refresh_req,
    input  logic        refresh_grant,
    output logic        refresh_done,
    output logic        refresh_overrun
);

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int unsigned POWERUP_CYC = 16;
    localparam int unsigned REF_INT     = 64;
`else
    localparam int unsigned POWERUP_CYC = POWERUP_US * CLK_MHZ;
    localparam int unsigned REF_INT     = REFRESH_INTERVAL;
`endif

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;
    localparam logic [3:0]  PEND_MAX     = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POWERUP,
        S_PRE,
        S_WAIT_RP,
        S_INIT_REF,
        S_WAIT_RFC,
        S_LMR,
        S_WAIT_MRD,
        S_READY,
        S_PER_REF,
        S_PER_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_next;
    logic [3:0]  r_ref_cnt;
    logic [3:0]  w_ref_cnt_next;
    logic [15:0] r_timer;
    logic [15:0] w_timer_next;
    logic [3:0]  r_pending;
    logic [3:0]  w_pending_next;
    logic        r_overrun;
    logic        w_overrun_next;
    logic        w_timer_run;
    logic        w_wrap;
    logic        w_per_dec;
    logic [3:0]  r_cmd;
    logic [3:0]  w_cmd;
    logic [12:0] r_addr;
    logic [12:0] w_addr;
    logic        r_init_done;
    logic        r_refresh_req;
    logic        r_refresh_done;

    // State, wait counter and init refresh counter registers
    always_ff @(posedge dram_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_ref_cnt  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            r_ref_cnt  <= w_ref_cnt_next;
        end
    end

    // Next-state logic; the wait counter is loaded with (delay-1) on entry to each
    // command state, so the command cycle itself counts towards its own delay
    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = (r_wait_cnt != '0) ? r_wait_cnt - 16'd1 : '0;
        w_ref_cnt_next  = r_ref_cnt;
        if (!start) begin
            w_next_state    = S_IDLE;
            w_wait_cnt_next = '0;
            w_ref_cnt_next  = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_next_state    = S_POWERUP;
                    w_wait_cnt_next = 16'(POWERUP_CYC - 1);
                    w_ref_cnt_next  = '0;
                end
                S_POWERUP: begin
                    if (r_wait_cnt == '0) begin
                        w_next_state    = S_PRE;
                        w_wait_cnt_next = 16'(T_RP - 1);
                    end
                end
                S_PRE: begin
                    w_next_state = S_WAIT_RP;
                end
                S_WAIT_RP: begin
                    if (r_wait_cnt == '0) begin
                        w_next_state    = S_INIT_REF;
                        w_wait_cnt_next = 16'(T_RFC - 1);
                    end
                end
                S_INIT_REF: begin
                    w_next_state   = S_WAIT_RFC;
                    w_ref_cnt_next = r_ref_cnt + 4'd1;
                end
                S_WAIT_RFC: begin
                    if (r_wait_cnt == '0) begin
                        if (r_ref_cnt == 4'(INIT_REFRESHES)) begin
                            w_next_state    = S_LMR;
                            w_wait_cnt_next = 16'(T_MRD - 1);
                        end else begin
                            w_next_state    = S_INIT_REF;
                            w_wait_cnt_next = 16'(T_RFC - 1);
                        end
                    end
                end
                S_LMR: begin
                    w_next_state = S_WAIT_MRD;
                end
                S_WAIT_MRD: begin
                    if (r_wait_cnt == '0) begin
                        w_next_state = S_READY;
                    end
                end
                S_READY: begin
                    if (r_refresh_req && refresh_grant) begin
                        w_next_state    = S_PER_REF;
                        w_wait_cnt_next = 16'(T_RFC - 1);
                    end
                end
                S_PER_REF: begin
                    w_next_state = S_PER_WAIT;
                end
                S_PER_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        w_next_state = S_READY;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Refresh interval timer and pending-refresh bookkeeping
    always_comb begin
        w_timer_run    = (r_state == S_READY) || (r_state == S_PER_REF) ||
                         (r_state == S_PER_WAIT);
        w_wrap         = w_timer_run && (r_timer == 16'(REF_INT - 1));
        w_per_dec      = (r_state == S_PER_REF);
        w_timer_next   = r_timer;
        w_pending_next = r_pending;
        w_overrun_next = r_overrun;
        if (!start) begin
            w_timer_next   = '0;
            w_pending_next = '0;
            w_overrun_next = 1'b0;
        end else begin
            if (w_timer_run) begin
                w_timer_next = w_wrap ? '0 : r_timer + 16'd1;
            end
            // A wrap coinciding with a periodic refresh command cancels out
            if (w_wrap && !w_per_dec) begin
                if (r_pending == PEND_MAX) begin
                    w_overrun_next = 1'b1;
                end else begin
                    w_pending_next = r_pending + 4'd1;
                end
            end else if (w_per_dec && !w_wrap) begin
                w_pending_next = r_pending - 4'd1;
            end
        end
    end

    // Timer, pending count and sticky overrun registers
    always_ff @(posedge dram_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer   <= '0;
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_timer   <= w_timer_next;
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
        end
    end

    // Command decode from the next state so the registered pins line up with the state
    always_comb begin
        w_cmd  = CMD_NOP;
        w_addr = '0;
        unique case (w_next_state)
            S_IDLE:                 w_cmd = CMD_INHIBIT;
            S_PRE: begin
                w_cmd  = CMD_PRE;
                w_addr = ADDR_PRE_ALL;
            end
            S_INIT_REF, S_PER_REF:  w_cmd = CMD_REF;
            S_LMR: begin
                w_cmd  = CMD_LMR;
                w_addr = MODE_REG;
            end
            default:                w_cmd = CMD_NOP;
        endcase
    end

    // Registered command bus and status outputs
    always_ff @(posedge dram_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd          <= CMD_INHIBIT;
            r_addr         <= '0;
            r_init_done    <= 1'b0;
            r_refresh_req  <= 1'b0;
            r_refresh_done <= 1'b0;
        end else begin
            r_cmd          <= w_cmd;
            r_addr         <= w_addr;
            r_init_done    <= start && (r_init_done || (w_next_state == S_READY));
            r_refresh_req  <= (w_next_state == S_READY) && (w_pending_next != '0);
            r_refresh_done <= start && (r_state == S_PER_WAIT) && (r_wait_cnt == '0);
        end
    end

    assign {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} = r_cmd;
    assign cmd_addr        = r_addr;
    assign cmd_ba          = '0;
    assign init_done       = r_init_done;
    assign refresh_req     = r_refresh_req;
    assign refresh_done    = r_refresh_done;
    assign refresh_overrun = r_overrun;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Testbench for sdram_init_refresh.
// The main instance uses parameters that give a 16-cycle power-up wait and a
// 64-cycle refresh interval whether or not SDRAM_INIT_FAST_SIM_EN is defined.
// A second instance with default parameters times the first PRECHARGE.
module tb_sdram_init_refresh;

    localparam logic [3:0] C_INH = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam int INTV = 64;

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int EXP_SLOW_PRE = 16;
`else
    localparam int EXP_SLOW_PRE = 33200;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        refresh_grant;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        init_done, refresh_req, refresh_done, refresh_overrun;

    logic        s_cs_n, s_ras_n, s_cas_n, s_we_n;
    logic [12:0] s_addr;
    logic [1:0]  s_ba;
    logic        s_init_done, s_req, s_done, s_ovr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    sdram_init_refresh #(
        .CLK_MHZ(16), .POWERUP_US(1), .INIT_REFRESHES(8), .T_RP(3), .T_RFC(10),
        .T_MRD(2), .REFRESH_INTERVAL(64), .MODE_REG(13'h030)
    ) dut (
        .dram_clk(clk), .reset_n(reset_n), .start(start),
        .cmd_cs_n(cs_n), .cmd_ras_n(ras_n), .cmd_cas_n(cas_n), .cmd_we_n(we_n),
        .cmd_addr(addr), .cmd_ba(ba), .init_done(init_done),
        .refresh_req(refresh_req), .refresh_grant(refresh_grant),
        .refresh_done(refresh_done), .refresh_overrun(refresh_overrun)
    );

    sdram_init_refresh u_slow (
        .dram_clk(clk), .reset_n(reset_n), .start(1'b1),
        .cmd_cs_n(s_cs_n), .cmd_ras_n(s_ras_n), .cmd_cas_n(s_cas_n), .cmd_we_n(s_we_n),
        .cmd_addr(s_addr), .cmd_ba(s_ba), .init_done(s_init_done),
        .refresh_req(s_req), .refresh_grant(1'b0),
        .refresh_done(s_done), .refresh_overrun(s_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] cmd_now();
        return {cs_n, ras_n, cas_n, we_n};
    endfunction

    // ---------------- behavioural model: a schedule of pin commands ----------------
    typedef struct packed {
        logic [3:0]  cmd;
        logic [12:0] addr;
    } pin_t;

    pin_t q[$];
    pin_t m_out     = '{C_INH, 13'h0};
    bit   m_active  = 0;  // a start-high session is in progress
    bit   m_ready   = 0;  // init sequence fully emitted
    bit   m_per     = 0;  // a periodic refresh window is in progress
    bit   m_prev_ar = 0;  // previous cycle showed a periodic AUTO REFRESH
    bit   m_req     = 0;
    bit   m_done    = 0;
    bit   m_ovr     = 0;
    int   m_timer   = 0;  // cycles since READY entry, modulo INTV
    int   m_pend    = 0;

    task automatic push(input logic [3:0] c, input logic [12:0] a, input int n);
        for (int i = 0; i < n; i++) q.push_back('{c, a});
    endtask

    task automatic model_step(input bit rn, input bit st, input bit gr);
        bit wrap;
        if (!rn || !st) begin
            q.delete();
            m_out = '{C_INH, 13'h0};
            m_active = 0; m_ready = 0; m_per = 0; m_prev_ar = 0;
            m_req = 0; m_done = 0; m_ovr = 0; m_timer = 0; m_pend = 0;
            return;
        end
        if (!m_active) begin
            m_active = 1;
            push(C_NOP, 13'h0, 16);
            push(C_PRE, 13'h400, 1);
            push(C_NOP, 13'h0, 2);
            for (int k = 0; k < 8; k++) begin
                push(C_REF, 13'h0, 1);
                push(C_NOP, 13'h0, 9);
            end
            push(C_LMR, 13'h030, 1);
            push(C_NOP, 13'h0, 1);
        end else if (m_ready) begin
            wrap = (m_timer == INTV - 1);
            m_timer = wrap ? 0 : m_timer + 1;
            if (wrap && !m_prev_ar) begin
                if (m_pend == 8) m_ovr = 1;
                else m_pend++;
            end else if (m_prev_ar && !wrap) begin
                m_pend--;
            end
            if (m_req && gr) begin
                push(C_REF, 13'h0, 1);
                push(C_NOP, 13'h0, 9);
                m_per = 1;
            end
        end
        m_done = 0;
        if (q.size() != 0) begin
            m_out = q.pop_front();
        end else begin
            m_out = '{C_NOP, 13'h0};
            if (!m_ready) m_ready = 1;
            else if (m_per) begin
                m_done = 1;
                m_per = 0;
            end
        end
        m_prev_ar = m_ready && (m_out.cmd == C_REF);
        m_req = m_ready && !m_per && (m_pend != 0);
    endtask

    // Compare process: model advances on every rising edge, DUT checked 1 time unit later
    always @(posedge clk) begin
        model_step(reset_n, start, refresh_grant);
        cyc = reset_n ? cyc + 1 : 0;
        #1;
        chk("cmd",       {28'd0, cmd_now()},       {28'd0, m_out.cmd});
        chk("addr",      {19'd0, addr},            {19'd0, m_out.addr});
        chk("ba",        {30'd0, ba},              32'd0);
        chk("init_done", {31'd0, init_done},       {31'd0, m_ready});
        chk("req",       {31'd0, refresh_req},     {31'd0, m_req});
        chk("done",      {31'd0, refresh_done},    {31'd0, m_done});
        chk("overrun",   {31'd0, refresh_overrun}, {31'd0, m_ovr});
    end

    // First-PRECHARGE timing of the default-parameter instance
    bit s_seen = 0;
    int s_pre  = 0;
    always @(posedge clk) begin
        #1;
        if (!s_seen && reset_n && ({s_cs_n, s_ras_n, s_cas_n, s_we_n} == C_PRE)) begin
            s_seen = 1;
            s_pre  = cyc;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_req(input logic val, input int bound, input string name);
        int n = 0;
        while (refresh_req !== val && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, refresh_req}, {31'd0, val});
    endtask

    // ---------------- directed stimulus with hand-computed checkpoints ----------------
    initial begin
        int r0, r1, n, n_done, k;
        bit fin;
        reset_n = 1'b0;
        start = 1'b1;
        refresh_grant = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd",  {28'd0, cmd_now()}, {28'd0, C_INH});
        chk("rst_addr", {19'd0, addr}, 32'd0);
        chk("rst_done", {29'd0, init_done, refresh_req, refresh_overrun}, 32'd0);
        reset_n = 1'b1;

        // Init trace: PRE at 17, AR#1 at 20, LMR at 100, READY at 102, req at 166
        wait_cyc(16);  chk("pwrup_nop", {28'd0, cmd_now()}, {28'd0, C_NOP});
        wait_cyc(17);  chk("pre_cmd",   {28'd0, cmd_now()}, {28'd0, C_PRE});
        chk("pre_addr", {19'd0, addr}, 32'h400);
        wait_cyc(20);  chk("ar1_cmd",   {28'd0, cmd_now()}, {28'd0, C_REF});
        wait_cyc(100); chk("lmr_cmd",   {28'd0, cmd_now()}, {28'd0, C_LMR});
        chk("lmr_addr", {19'd0, addr}, 32'h030);
        wait_cyc(101); chk("init_101",  {31'd0, init_done}, 32'd0);
        wait_cyc(102); chk("init_102",  {31'd0, init_done}, 32'd1);
        wait_cyc(165); chk("req_165",   {31'd0, refresh_req}, 32'd0);
        wait_cyc(166); chk("req_166",   {31'd0, refresh_req}, 32'd1);

        // One granted refresh: command next cycle, done 10 cycles later
        refresh_grant = 1'b1;
        @(negedge clk);
        refresh_grant = 1'b0;
        chk("grant_ar",  {28'd0, cmd_now()}, {28'd0, C_REF});
        chk("grant_req", {31'd0, refresh_req}, 32'd0);
        wait_cyc(176); chk("done_176", {31'd0, refresh_done}, 32'd0);
        wait_cyc(177); chk("done_177", {31'd0, refresh_done}, 32'd1);

        // Nine intervals without grant: saturation and overrun
        wait_cyc(177 + 9 * INTV + 5);
        chk("ovr_set", {31'd0, refresh_overrun}, 32'd1);
        chk("ovr_req", {31'd0, refresh_req}, 32'd1);

        // Drain: grant whenever requested until a refresh completes with req low
        n = 0; n_done = 0; fin = 0;
        while (!fin && n < 600) begin
            if (refresh_done) n_done++;
            if (refresh_done && !refresh_req) fin = 1;
            refresh_grant = refresh_req && !fin;
            @(negedge clk);
            n++;
        end
        refresh_grant = 1'b0;
        chk("drain_fin",   {31'd0, fin}, 32'd1);
        chk("drain_count", {31'd0, n_done >= 8}, 32'd1);
        chk("drain_ovr",   {31'd0, refresh_overrun}, 32'd1);

        // Grants while req is low produce no command
        for (int i = 0; i < 3; i++) begin
            if (refresh_req == 1'b0) begin
                refresh_grant = 1'b1;
                @(negedge clk);
                refresh_grant = 1'b0;
                chk("ign_grant", {28'd0, cmd_now()}, {28'd0, C_NOP});
            end
        end

        // Timer wrap in the PER_REF cycle: pending unchanged, req back on READY return
        wait_req(1'b1, 100, "wrap_req_rise");
        n = 0;
        while (m_timer != INTV - 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_align", m_timer, INTV - 2);
        refresh_grant = 1'b1;
        k = cyc;
        @(negedge clk);
        refresh_grant = 1'b0;
        chk("wrap_ar", {28'd0, cmd_now()}, {28'd0, C_REF});
        wait_cyc(k + 11);
        chk("wrap_done", {31'd0, refresh_done}, 32'd1);
        chk("wrap_req",  {31'd0, refresh_req}, 32'd1);

        // Drop start: INHIBIT and cleared status on the next cycle
        start = 1'b0;
        @(negedge clk);
        chk("stop_cmd",  {28'd0, cmd_now()}, {28'd0, C_INH});
        chk("stop_stat", {29'd0, init_done, refresh_req, refresh_overrun}, 32'd0);
        start = 1'b1;
        r0 = cyc + 1;
        wait_cyc(r0 + 49); chk("re_ar4", {28'd0, cmd_now()}, {28'd0, C_REF});
        wait_cyc(r0 + 52);
        start = 1'b0;   // during the 4th WAIT_RFC
        @(negedge clk);
        chk("mid_cmd",  {28'd0, cmd_now()}, {28'd0, C_INH});
        chk("mid_init", {31'd0, init_done}, 32'd0);
        start = 1'b1;
        r1 = cyc + 1;
        wait_cyc(r1);       chk("rs_nop",  {28'd0, cmd_now()}, {28'd0, C_NOP});
        wait_cyc(r1 + 16);  chk("rs_pre",  {28'd0, cmd_now()}, {28'd0, C_PRE});
        chk("rs_pre_addr", {19'd0, addr}, 32'h400);
        wait_cyc(r1 + 100); chk("rs_init0", {31'd0, init_done}, 32'd0);
        wait_cyc(r1 + 101); chk("rs_init1", {31'd0, init_done}, 32'd1);

        // Default-parameter instance: first PRECHARGE relative to the start edge
        while (!s_seen && cyc < 40000) @(negedge clk);
        chk("slow_seen", {31'd0, s_seen}, 32'd1);
        chk("slow_pre_delay", s_pre - 1, EXP_SLOW_PRE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
